alu_arbiter: RTL and testbench

- Shares one combinational RV32 integer ALU (alu32) between N_REQ requesters, e.g. the execute stage and the address-generation / branch-target path.
- Round-robin arbitration with valid/ready handshakes on each request port.
- One registered response stage with backpressure; responses carry the requester index and a caller tag.
- Instantiates alu32 internally and drives its a, b, op_funct3 and op_funct7 inputs.

---
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational RV32 integer ALU between
// N_REQ requesters and returns each result through a single registered, backpressured response stage.

module alu32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op_funct3,
    input  logic        op_funct7,
    output logic [31:0] result
);
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] sra_res;
    logic        [4:0]  shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];
    // Kept in its own signed net so the ternary below cannot demote >>> to a logical shift.
    assign sra_res = a_s >>> shamt;

    always_comb begin
        result = 32'd0;
        case (op_funct3)
            F3_ADD:  result = op_funct7 ? (a - b) : (a + b);
            F3_SLL:  result = a << shamt;
            F3_SLT:  result = {31'd0, (a_s < b_s)};
            F3_SLTU: result = {31'd0, (a < b)};
            F3_XOR:  result = a ^ b;
            F3_SR:   result = op_funct7 ? sra_res : (a >> shamt);
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = 32'd0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter  int N_REQ = 2,
    parameter  int TAG_W = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][31:0]       req_a,
    input  logic [N_REQ-1:0][31:0]       req_b,
    input  logic [N_REQ-1:0][2:0]        req_funct3,
    input  logic [N_REQ-1:0]             req_funct7,
    input  logic [N_REQ-1:0][TAG_W-1:0]  req_tag,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_out,
    output logic [ID_W-1:0]              rsp_id,
    output logic [TAG_W-1:0]             rsp_tag
);
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SR  = 3'b101;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_out_q,   rsp_out_d;
    logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             can_issue;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [31:0]      alu_a, alu_b, alu_res;
    logic [2:0]       alu_f3;
    logic             alu_f7;

    assign can_issue = !flush && (!rsp_valid_q || rsp_ready);

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (rst_n && can_issue) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!grant_vld && req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_f3 = 3'd0;
        alu_f7 = 1'b0;
        if (grant_vld) begin
            alu_a  = req_a[grant_idx];
            alu_b  = req_b[grant_idx];
            alu_f3 = req_funct3[grant_idx];
            // funct7 only selects sub/sra; masking it keeps every funct3 a defined op.
            alu_f7 = ((alu_f3 == F3_ADD) || (alu_f3 == F3_SR)) && req_funct7[grant_idx];
        end
    end

    alu32 u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .op_funct3 (alu_f3),
        .op_funct7 (alu_f7),
        .result    (alu_res)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_vld) begin
            rsp_valid_d = 1'b1;
            rsp_out_d   = alu_res;
            rsp_id_d    = grant_idx;
            rsp_tag_d   = req_tag[grant_idx];
            if (int'(grant_idx) == N_REQ - 1) rr_ptr_d = '0;
            else                              rr_ptr_d = grant_idx + 1'b1;
        end else if (flush || rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= 32'd0;
            rsp_id_q    <= '0;
            rsp_tag_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_tag   = rsp_tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N_REQ=2): inputs change on the falling edge,
// req_ready is sampled mid-low-phase and responses #1 after the rising edge.

module tb_alu_arbiter;
    localparam int N_REQ = 2;
    localparam int TAG_W = 4;

    logic                        clk;
    logic                        rst_n;
    logic                        flush;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][31:0]      req_a;
    logic [N_REQ-1:0][31:0]      req_b;
    logic [N_REQ-1:0][2:0]       req_funct3;
    logic [N_REQ-1:0]            req_funct7;
    logic [N_REQ-1:0][TAG_W-1:0] req_tag;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [31:0]                 rsp_out;
    logic [0:0]                  rsp_id;
    logic [TAG_W-1:0]            rsp_tag;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int p, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        req_funct3[p] = f3;
        req_funct7[p] = f7;
        req_a[p]      = a;
        req_b[p]      = b;
        req_tag[p]    = tag;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_out !== 32'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", rsp_out); end
        total++; if (rsp_id !== 1'b0 || rsp_tag !== 4'd0) begin bad++; $display("FAIL reset_id_tag got=%b/%h exp=0/0", rsp_id, rsp_tag); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h1, 4'd3);
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
        total++; if (rsp_out !== 32'h8000_0000) begin bad++; $display("FAIL single_out got=%h exp=80000000", rsp_out); end
        total++; if (rsp_id !== 1'b0 || rsp_tag !== 4'd3) begin bad++; $display("FAIL single_id_tag got=%b/%h exp=0/3", rsp_id, rsp_tag); end
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_ops();
        logic [2:0]  f3  [8] = '{3'b000, 3'b101, 3'b110, 3'b010, 3'b011, 3'b001, 3'b100, 3'b111};
        logic        f7  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] va  [8] = '{32'd5, 32'h8000_0000, 32'hF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h1, 32'hFF00_FF00, 32'h1234_5678};
        logic [31:0] vb  [8] = '{32'd7, 32'h24, 32'h0F, 32'h1, 32'h1, 32'h21, 32'h0FF0_0FF0, 32'h0F0F_0F0F};
        logic [31:0] exp [8] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'hFF, 32'h1, 32'h0,
                                 32'h2, 32'hF0F0_F0F0, 32'h0204_0608};
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(1, f3[i], f7[i], va[i], vb[i], 4'(i + 8));
            req_valid = 2'b10;
            #1;
            total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL op%0d_ready got=%b exp=10", i, req_ready); end
            @(posedge clk); #1;
            total++; if (rsp_out !== exp[i]) begin bad++; $display("FAIL op%0d_out got=%h exp=%h", i, rsp_out, exp[i]); end
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_tag !== 4'(i + 8))
                begin bad++; $display("FAIL op%0d_meta got=%b/%b/%h exp=1/1/%h", i, rsp_valid, rsp_id, rsp_tag, 4'(i + 8)); end
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic        g;
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 1'b0, 32'd10, 32'd1, 4'hA);
        set_req(1, 3'b000, 1'b0, 32'd20, 32'd2, 4'hB);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            g       = 1'(i % 2);
            exp_rdy = g ? 2'b10 : 2'b01;
            #1;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr%0d_ready got=%b exp=%b", i, req_ready, exp_rdy); end
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b1 || rsp_id !== g) begin bad++; $display("FAIL rr%0d_id got=%b/%b exp=1/%b", i, rsp_valid, rsp_id, g); end
            total++; if (rsp_out !== (g ? 32'd22 : 32'd11) || rsp_tag !== (g ? 4'hB : 4'hA))
                begin bad++; $display("FAIL rr%0d_data got=%h/%h", i, rsp_out, rsp_tag); end
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 1'b0, 32'd100, 32'd1, 4'd5);
        req_valid = 2'b01;
        @(posedge clk); #1;
        total++; if (rsp_out !== 32'd101) begin bad++; $display("FAIL bp_first got=%h exp=65", rsp_out); end
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 3'b000, 1'b0, 32'd200, 32'd3, 4'd6);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp%0d_ready got=%b exp=00", i, req_ready); end
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b1 || rsp_out !== 32'd101 || rsp_id !== 1'b0 || rsp_tag !== 4'd5)
                begin bad++; $display("FAIL bp%0d_hold got=%b/%h/%b/%h exp=1/65/0/5", i, rsp_valid, rsp_out, rsp_id, rsp_tag); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_release_ready got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_out !== 32'd203 || rsp_tag !== 4'd6)
            begin bad++; $display("FAIL bp_release_out got=%b/%h/%h exp=1/cb/6", rsp_valid, rsp_out, rsp_tag); end
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        set_req(1, 3'b000, 1'b0, 32'd1, 32'd1, 4'd7);
        req_valid = 2'b10;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_out !== 32'd2) begin bad++; $display("FAIL flush_setup got=%b/%h exp=1/2", rsp_valid, rsp_out); end
        @(negedge clk);
        set_req(1, 3'b000, 1'b0, 32'd3, 32'd4, 4'd8);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL flush_ready got=%b exp=00", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", rsp_valid); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL flush_after_ready got=%b exp=10", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_out !== 32'd7 || rsp_id !== 1'b1 || rsp_tag !== 4'd8)
            begin bad++; $display("FAIL flush_after_rsp got=%b/%h/%b/%h exp=1/7/1/8", rsp_valid, rsp_out, rsp_id, rsp_tag); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 1'b0, 32'd1, 32'd1, 4'd1);
        req_valid = 2'b01;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin bad++; $display("FAIL ar_setup got=%b/%b exp=1/0", rsp_valid, rsp_id); end
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || rsp_out !== 32'd0) begin bad++; $display("FAIL ar_immediate got=%b/%h exp=0/0", rsp_valid, rsp_out); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL ar_ready got=%b exp=00", req_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 3'b000, 1'b0, 32'd9, 32'd9, 4'd2);
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL ar_first_ready got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_id !== 1'b0 || rsp_out !== 32'd2) begin bad++; $display("FAIL ar_first_rsp got=%b/%h exp=0/2", rsp_id, rsp_out); end
        @(negedge clk);
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL ar_second_ready got=%b exp=10", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_id !== 1'b1 || rsp_out !== 32'd18) begin bad++; $display("FAIL ar_second_rsp got=%b/%h exp=1/12", rsp_id, rsp_out); end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        rsp_ready  = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_funct3 = '0;
        req_funct7 = '0;
        req_tag    = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_single();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
